// File: rtl/text_pkg.sv
// Shared constants and types for the character writer.
package text_pkg;

  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] CHAR_CR       = 8'h0D;
  localparam logic [7:0] CHAR_BS       = 8'h08;
  localparam logic [7:0] CHAR_FF       = 8'h0C;
  localparam logic [7:0] CHAR_TAB      = 8'h09;
  localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1,
    CLEAR_ROW = 2'd2
  } text_writer_state_t;

  // True for bytes that are stored as glyphs.
  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= CHAR_PRINT_LO) && (ch <= CHAR_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_writer_if.sv
// Byte stream in, frame-buffer write port out.
interface text_writer_if #(
  parameter int unsigned p_addr_w = 13
);

  logic                istream_val;
  logic                istream_rdy;
  logic [7:0]          istream_msg;
  logic                wr_en;
  logic [p_addr_w-1:0] wr_addr;
  logic [7:0]          wr_data;

  modport master (
    output istream_val,
    output istream_msg,
    input  istream_rdy,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  istream_val,
    input  istream_msg,
    output istream_rdy,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/text_cursor.sv
// Cursor position and scroll offset; one command per cycle.
module text_cursor
  import text_pkg::*;
#(
  parameter  int unsigned p_cols  = 80,
  parameter  int unsigned p_rows  = 60,
  localparam int unsigned c_col_w = $clog2(p_cols),
  localparam int unsigned c_row_w = $clog2(p_rows)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic               cr,
  input  logic               bs,
  input  logic               newline,
  input  logic               tab,
  input  logic               home,
  output logic [c_row_w-1:0] cursor_row,
  output logic [c_col_w-1:0] cursor_col,
  output logic [c_row_w-1:0] top_row,
  output logic [c_row_w-1:0] phys_row_c,
  output logic               scroll_c
);

  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(p_cols - 1);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(p_rows - 1);

  logic [c_col_w-1:0] col_q, col_n;
  logic [c_row_w-1:0] row_q, row_n;
  logic [c_row_w-1:0] top_q, top_n;
  logic               nl;
  logic [c_col_w+3:0] tab_pos;
  logic [c_row_w:0]   phys_sum;

  // Next cursor position; a newline on the last row rotates the top row instead.
  always_comb begin
    col_n   = col_q;
    row_n   = row_q;
    top_n   = top_q;
    nl      = 1'b0;
    tab_pos = ({4'b0000, col_q} | (c_col_w+4)'(7)) + (c_col_w+4)'(1);
    if (home) begin
      col_n = '0;
      row_n = '0;
      top_n = '0;
    end else if (advance) begin
      if (col_q == c_last_col) begin
        col_n = '0;
        nl    = 1'b1;
      end else begin
        col_n = col_q + c_col_w'(1);
      end
    end else if (cr) begin
      col_n = '0;
    end else if (newline) begin
      col_n = '0;
      nl    = 1'b1;
    end else if (bs) begin
      if (col_q != '0) col_n = col_q - c_col_w'(1);
    end else if (tab) begin
      if (tab_pos >= (c_col_w+4)'(p_cols)) begin
        col_n = '0;
        nl    = 1'b1;
      end else begin
        col_n = c_col_w'(tab_pos);
      end
    end
    if (nl) begin
      if (row_q != c_last_row) row_n = row_q + c_row_w'(1);
      else top_n = (top_q == c_last_row) ? '0 : top_q + c_row_w'(1);
    end
  end

  assign scroll_c   = nl && (row_q == c_last_row);
  assign phys_sum   = {1'b0, top_q} + {1'b0, row_q};
  assign phys_row_c = (phys_sum >= (c_row_w+1)'(p_rows))
                    ? c_row_w'(phys_sum - (c_row_w+1)'(p_rows))
                    : c_row_w'(phys_sum);

  // Cursor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      top_q <= '0;
    end else begin
      col_q <= col_n;
      row_q <= row_n;
      top_q <= top_n;
    end
  end

  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign top_row    = top_q;

endmodule

// File: rtl/text_writer.sv
// Writes an ASCII byte stream into the character frame buffer.
// Optional TAB handling is enabled by defining TEXT_WRITER_TAB_EN.
module text_writer
  import text_pkg::*;
#(
  parameter  int unsigned p_cols   = 80,
  parameter  int unsigned p_rows   = 60,
  localparam int unsigned c_addr_w = $clog2(p_cols * p_rows),
  localparam int unsigned c_col_w  = $clog2(p_cols),
  localparam int unsigned c_row_w  = $clog2(p_rows)
) (
  input  logic               clk,
  input  logic               rst,
  text_writer_if.slave       bus,
  output logic [c_row_w-1:0] top_row,
  output logic [c_row_w-1:0] cursor_row,
  output logic [c_col_w-1:0] cursor_col,
  output logic               busy
);

  localparam int unsigned c_total = p_cols * p_rows;
  localparam int unsigned c_cnt_w = $clog2(c_total + 1);

  text_writer_state_t  state_q, state_n;
  logic [c_cnt_w-1:0]  cnt_q, cnt_n;
  logic [c_addr_w-1:0] clr_base_q, clr_base_n;
  logic                wr_en_q, wr_en_n;
  logic [c_addr_w-1:0] wr_addr_q, wr_addr_n;
  logic [7:0]          wr_data_q, wr_data_n;
  logic                rdy_q;
  logic                busy_q;

  logic                accept_c;
  logic                cmd_advance, cmd_cr, cmd_bs, cmd_newline, cmd_tab, cmd_home;
  logic [c_row_w-1:0]  phys_row_c;
  logic                scroll_c;
  logic [c_addr_w-1:0] row_base_c;

  text_cursor #(
    .p_cols (p_cols),
    .p_rows (p_rows)
  ) u_cursor (
    .clk        (clk),
    .rst        (rst),
    .advance    (cmd_advance),
    .cr         (cmd_cr),
    .bs         (cmd_bs),
    .newline    (cmd_newline),
    .tab        (cmd_tab),
    .home       (cmd_home),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .top_row    (top_row),
    .phys_row_c (phys_row_c),
    .scroll_c   (scroll_c)
  );

  // rdy is only ever high in IDLE, so an accept implies IDLE.
  assign accept_c   = bus.istream_val && rdy_q;
  assign row_base_c = c_addr_w'(phys_row_c) * c_addr_w'(p_cols);

  // Decode an accepted byte into a one-hot cursor command.
  always_comb begin
    cmd_advance = 1'b0;
    cmd_cr      = 1'b0;
    cmd_bs      = 1'b0;
    cmd_newline = 1'b0;
    cmd_tab     = 1'b0;
    cmd_home    = 1'b0;
    if (accept_c) begin
      if (is_printable(bus.istream_msg)) begin
        cmd_advance = 1'b1;
      end else begin
        case (bus.istream_msg)
          CHAR_LF: cmd_newline = 1'b1;
          CHAR_CR: cmd_cr      = 1'b1;
          CHAR_BS: cmd_bs      = (cursor_col != '0);
          CHAR_FF: cmd_home    = 1'b1;
`ifdef TEXT_WRITER_TAB_EN
          CHAR_TAB: cmd_tab    = 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  // Next state and next write-port values.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    clr_base_n = clr_base_q;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr_q;
    wr_data_n  = wr_data_q;
    case (state_q)
      CLEAR_ALL: begin
        if (cnt_q < c_cnt_w'(c_total)) begin
          wr_en_n   = 1'b1;
          wr_addr_n = c_addr_w'(cnt_q);
          wr_data_n = CHAR_SPACE;
          cnt_n     = cnt_q + c_cnt_w'(1);
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      IDLE: begin
        if (cmd_advance) begin
          wr_en_n   = 1'b1;
          wr_addr_n = row_base_c + c_addr_w'(cursor_col);
          wr_data_n = bus.istream_msg;
        end else if (cmd_bs) begin
          wr_en_n   = 1'b1;
          wr_addr_n = row_base_c + c_addr_w'(cursor_col - c_col_w'(1));
          wr_data_n = CHAR_SPACE;
        end
        if (cmd_home) begin
          state_n = CLEAR_ALL;
          cnt_n   = '0;
        end else if (scroll_c) begin
          // The row leaving the top of the screen is recycled as the new bottom row.
          state_n    = CLEAR_ROW;
          cnt_n      = '0;
          clr_base_n = c_addr_w'(top_row) * c_addr_w'(p_cols);
        end
      end
      CLEAR_ROW: begin
        if (cnt_q < c_cnt_w'(p_cols)) begin
          wr_en_n   = 1'b1;
          wr_addr_n = clr_base_q + c_addr_w'(cnt_q);
          wr_data_n = CHAR_SPACE;
          cnt_n     = cnt_q + c_cnt_w'(1);
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = CLEAR_ALL;
        cnt_n   = '0;
      end
    endcase
  end

  // State and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ALL;
      cnt_q      <= '0;
      clr_base_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= CHAR_SPACE;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      clr_base_q <= clr_base_n;
      wr_en_q    <= wr_en_n;
      wr_addr_q  <= wr_addr_n;
      wr_data_q  <= wr_data_n;
      rdy_q      <= (state_n == IDLE);
      busy_q     <= (state_n != IDLE);
    end
  end

  assign bus.istream_rdy = rdy_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer on a 4x3 screen (plus 16x3 when TEXT_WRITER_TAB_EN).
module tb_text_writer;

  localparam int unsigned p_cols   = 4;
  localparam int unsigned p_rows   = 3;
  localparam int unsigned c_addr_w = $clog2(p_cols * p_rows);

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] top_row;
  logic [1:0] cursor_row;
  logic [1:0] cursor_col;
  logic       busy;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  text_writer_if #(.p_addr_w(c_addr_w)) bus ();

  text_writer #(
    .p_cols (p_cols),
    .p_rows (p_rows)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .top_row    (top_row),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

`ifdef TEXT_WRITER_TAB_EN
  logic [1:0] top16;
  logic [1:0] row16;
  logic [3:0] col16;
  logic       busy16;

  text_writer_if #(.p_addr_w(6)) bus16 ();

  text_writer #(
    .p_cols (16),
    .p_rows (3)
  ) dut16 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus16),
    .top_row    (top16),
    .cursor_row (row16),
    .cursor_col (col16),
    .busy       (busy16)
  );
`endif

  // Waits (bounded) for rdy, offers one byte, returns at the negedge of cycle N+1.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (bus.istream_rdy !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (bus.istream_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL send_wait_rdy got=%b want=1", bus.istream_rdy);
    end
    bus.istream_val = 1'b1;
    bus.istream_msg = b;
    @(posedge clk);
    @(negedge clk);
    bus.istream_val = 1'b0;
    bus.istream_msg = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.istream_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy, busy, cursor_row, cursor_col, top_row, bus.wr_addr, bus.wr_data}
        !== {1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 4'd0, 8'h20}) begin
      n_bad++;
      $display("FAIL reset_state got=%b_%b_%b_%0d_%0d_%0d_%0d_%h want=0_0_1_0_0_0_0_20",
               bus.wr_en, bus.istream_rdy, busy, cursor_row, cursor_col, top_row, bus.wr_addr, bus.wr_data);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy} !== {1'b1, 4'(i), 8'h20, 1'b0}) begin
        n_bad++;
        $display("FAIL clear_all_write%0d got en=%b addr=%0d data=%h rdy=%b want en=1 addr=%0d data=20 rdy=0",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy, i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL clear_all_done got en/rdy/busy=%b want 010", {bus.wr_en, bus.istream_rdy, busy});
    end
  endtask

  task automatic test_print();
    send_byte(8'h41);
    n_cmp++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, cursor_col} !== {1'b1, 4'd0, 8'h41, 2'd1}) begin
      n_bad++;
      $display("FAIL print_A got en=%b addr=%0d data=%h col=%0d want 1/0/41/1", bus.wr_en, bus.wr_addr, bus.wr_data, cursor_col);
    end
    send_byte(8'h42);
    n_cmp++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, cursor_row, cursor_col} !== {1'b1, 4'd1, 8'h42, 2'd0, 2'd2}) begin
      n_bad++;
      $display("FAIL print_B got en=%b addr=%0d data=%h row=%0d col=%0d want 1/1/42/0/2",
               bus.wr_en, bus.wr_addr, bus.wr_data, cursor_row, cursor_col);
    end
    send_byte(8'h0D);
    n_cmp++;
    if ({bus.wr_en, cursor_row, cursor_col} !== {1'b0, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL cr got en=%b row=%0d col=%0d want 0/0/0", bus.wr_en, cursor_row, cursor_col);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] s [4];
    s = '{8'h41, 8'h42, 8'h43, 8'h44};
    for (int i = 0; i < 3; i++) begin
      send_byte(s[i]);
      n_cmp++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 4'(i), s[i]}) begin
        n_bad++;
        $display("FAIL wrap_char%0d got en=%b addr=%0d data=%h want 1/%0d/%h", i, bus.wr_en, bus.wr_addr, bus.wr_data, i, s[i]);
      end
    end
    send_byte(s[3]);
    n_cmp++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, cursor_row, cursor_col, bus.istream_rdy}
        !== {1'b1, 4'd3, 8'h44, 2'd1, 2'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL wrap_last got en=%b addr=%0d data=%h row=%0d col=%0d rdy=%b want 1/3/44/1/0/1",
               bus.wr_en, bus.wr_addr, bus.wr_data, cursor_row, cursor_col, bus.istream_rdy);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy} !== 2'b01) begin
      n_bad++;
      $display("FAIL wrap_no_clear got en/rdy=%b want 01", {bus.wr_en, bus.istream_rdy});
    end
  endtask

  task automatic test_scroll();
    send_byte(8'h0A);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy, cursor_row, cursor_col, top_row} !== {1'b0, 1'b1, 2'd2, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL lf_plain got en=%b rdy=%b row=%0d col=%0d top=%0d want 0/1/2/0/0",
               bus.wr_en, bus.istream_rdy, cursor_row, cursor_col, top_row);
    end
    send_byte(8'h0A);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy, busy, cursor_row, cursor_col, top_row} !== {1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd1}) begin
      n_bad++;
      $display("FAIL lf_scroll got en=%b rdy=%b busy=%b row=%0d col=%0d top=%0d want 0/0/1/2/0/1",
               bus.wr_en, bus.istream_rdy, busy, cursor_row, cursor_col, top_row);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy} !== {1'b1, 4'(i), 8'h20, 1'b0}) begin
        n_bad++;
        $display("FAIL lf_clear%0d got en=%b addr=%0d data=%h rdy=%b want 1/%0d/20/0",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy, i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy} !== 2'b01) begin
      n_bad++;
      $display("FAIL lf_clear_done got en/rdy=%b want 01", {bus.wr_en, bus.istream_rdy});
    end
    send_byte(8'h58);
    n_cmp++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, cursor_col} !== {1'b1, 4'd0, 8'h58, 2'd1}) begin
      n_bad++;
      $display("FAIL after_scroll_X got en=%b addr=%0d data=%h col=%0d want 1/0/58/1",
               bus.wr_en, bus.wr_addr, bus.wr_data, cursor_col);
    end
  endtask

  task automatic test_wrap_scroll();
    send_byte(8'h59);
    send_byte(8'h5A);
    n_cmp++;
    if ({bus.wr_addr, bus.wr_data, cursor_col} !== {4'd2, 8'h5A, 2'd3}) begin
      n_bad++;
      $display("FAIL ws_Z got addr=%0d data=%h col=%0d want 2/5a/3", bus.wr_addr, bus.wr_data, cursor_col);
    end
    send_byte(8'h57);
    n_cmp++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy, top_row, cursor_row, cursor_col}
        !== {1'b1, 4'd3, 8'h57, 1'b0, 2'd2, 2'd2, 2'd0}) begin
      n_bad++;
      $display("FAIL ws_W got en=%b addr=%0d data=%h rdy=%b top=%0d row=%0d col=%0d want 1/3/57/0/2/2/0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy, top_row, cursor_row, cursor_col);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy} !== {1'b1, 4'(4 + i), 8'h20, 1'b0}) begin
        n_bad++;
        $display("FAIL ws_clear%0d got en=%b addr=%0d data=%h rdy=%b want 1/%0d/20/0",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy, 4 + i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy} !== 2'b01) begin
      n_bad++;
      $display("FAIL ws_clear_done got en/rdy=%b want 01", {bus.wr_en, bus.istream_rdy});
    end
  endtask

  task automatic test_bs();
    send_byte(8'h08);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy, cursor_row, cursor_col} !== {1'b0, 1'b1, 2'd2, 2'd0}) begin
      n_bad++;
      $display("FAIL bs_col0 got en=%b rdy=%b row=%0d col=%0d want 0/1/2/0", bus.wr_en, bus.istream_rdy, cursor_row, cursor_col);
    end
    send_byte(8'h50);
    n_cmp++;
    if ({bus.wr_addr, bus.wr_data} !== {4'd4, 8'h50}) begin
      n_bad++;
      $display("FAIL bs_P got addr=%0d data=%h want 4/50", bus.wr_addr, bus.wr_data);
    end
    send_byte(8'h51);
    send_byte(8'h08);
    n_cmp++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, cursor_col} !== {1'b1, 4'd5, 8'h20, 2'd1}) begin
      n_bad++;
      $display("FAIL bs_col2 got en=%b addr=%0d data=%h col=%0d want 1/5/20/1", bus.wr_en, bus.wr_addr, bus.wr_data, cursor_col);
    end
  endtask

  task automatic test_other_bytes();
`ifndef TEXT_WRITER_TAB_EN
    send_byte(8'h09);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy, cursor_row, cursor_col} !== {1'b0, 1'b1, 2'd2, 2'd1}) begin
      n_bad++;
      $display("FAIL tab_ignored got en=%b rdy=%b row=%0d col=%0d want 0/1/2/1", bus.wr_en, bus.istream_rdy, cursor_row, cursor_col);
    end
`endif
    send_byte(8'h01);
    n_cmp++;
    if ({bus.wr_en, cursor_col} !== {1'b0, 2'd1}) begin
      n_bad++;
      $display("FAIL ctrl_01 got en=%b col=%0d want 0/1", bus.wr_en, cursor_col);
    end
    send_byte(8'h7F);
    n_cmp++;
    if ({bus.wr_en, cursor_col} !== {1'b0, 2'd1}) begin
      n_bad++;
      $display("FAIL del_7f got en=%b col=%0d want 0/1", bus.wr_en, cursor_col);
    end
    send_byte(8'h7E);
    n_cmp++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, cursor_col} !== {1'b1, 4'd5, 8'h7E, 2'd2}) begin
      n_bad++;
      $display("FAIL tilde_7e got en=%b addr=%0d data=%h col=%0d want 1/5/7e/2", bus.wr_en, bus.wr_addr, bus.wr_data, cursor_col);
    end
  endtask

  task automatic test_ff();
    send_byte(8'h0C);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy, busy, cursor_row, cursor_col, top_row} !== {1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL ff_home got en=%b rdy=%b busy=%b row=%0d col=%0d top=%0d want 0/0/1/0/0/0",
               bus.wr_en, bus.istream_rdy, busy, cursor_row, cursor_col, top_row);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy} !== {1'b1, 4'(i), 8'h20, 1'b0}) begin
        n_bad++;
        $display("FAIL ff_clear%0d got en=%b addr=%0d data=%h rdy=%b want 1/%0d/20/0",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.istream_rdy, i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.wr_en, bus.istream_rdy} !== 2'b01) begin
      n_bad++;
      $display("FAIL ff_done got en/rdy=%b want 01", {bus.wr_en, bus.istream_rdy});
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h41);
    n_cmp++;
    if ({bus.wr_addr, cursor_col} !== {4'd0, 2'd1}) begin
      n_bad++;
      $display("FAIL mid_A got addr=%0d col=%0d want 0/1", bus.wr_addr, cursor_col);
    end
    send_byte(8'h0C);
    repeat (3) @(negedge clk);
    test_reset();
  endtask

`ifdef TEXT_WRITER_TAB_EN
  task automatic send16(input logic [7:0] b);
    int waited = 0;
    while (bus16.istream_rdy !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (bus16.istream_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL send16_wait_rdy got=%b want=1", bus16.istream_rdy);
    end
    bus16.istream_val = 1'b1;
    bus16.istream_msg = b;
    @(posedge clk);
    @(negedge clk);
    bus16.istream_val = 1'b0;
    bus16.istream_msg = 8'h00;
  endtask

  task automatic test_tab();
    send16(8'h61);
    send16(8'h62);
    send16(8'h63);
    send16(8'h09);
    n_cmp++;
    if ({bus16.wr_en, row16, col16} !== {1'b0, 2'd0, 4'd8}) begin
      n_bad++;
      $display("FAIL tab_col3 got en=%b row=%0d col=%0d want 0/0/8", bus16.wr_en, row16, col16);
    end
    send16(8'h64);
    n_cmp++;
    if ({bus16.wr_addr, bus16.wr_data, col16} !== {6'd8, 8'h64, 4'd9}) begin
      n_bad++;
      $display("FAIL tab_d got addr=%0d data=%h col=%0d want 8/64/9", bus16.wr_addr, bus16.wr_data, col16);
    end
    send16(8'h09);
    n_cmp++;
    if ({bus16.wr_en, bus16.istream_rdy, row16, col16} !== {1'b0, 1'b1, 2'd1, 4'd0}) begin
      n_bad++;
      $display("FAIL tab_col9 got en=%b rdy=%b row=%0d col=%0d want 0/1/1/0", bus16.wr_en, bus16.istream_rdy, row16, col16);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.istream_val = 1'b0;
    bus.istream_msg = 8'h00;
`ifdef TEXT_WRITER_TAB_EN
    bus16.istream_val = 1'b0;
    bus16.istream_msg = 8'h00;
`endif
    test_reset();
    test_print();
    test_wrap();
    test_scroll();
    test_wrap_scroll();
    test_bs();
    test_other_bytes();
    test_ff();
    test_reset_mid();
`ifdef TEXT_WRITER_TAB_EN
    test_tab();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
